// File: rtl/sound_cue_arbiter.sv
// Arbitrates N_REQ cue requesters onto the shared sound-board trigger lines with hold/gap/reset timing.
// Optional SND_ARB_RR_EN selects round-robin winner selection; the default is fixed priority (lowest index wins).
//
// state | meaning
// IDLE  | trigger lines idle, requests and stop sampled
// HOLD  | granted cue driven on snd_sel
// GAP   | quiet interval, snd_sel idle, requests ignored
// RST   | snd_rst asserted to the sound board
module sound_cue_arbiter #(
  parameter int N_REQ    = 4,
  parameter int CNT_W    = 16,
  parameter int HOLD_CYC = 15000,
  parameter int GAP_CYC  = 5000,
  parameter int RST_CYC  = 1000
) (
  input  logic               PCLK,
  input  logic               PRESET,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [6*N_REQ-1:0] req_cue,
  output logic [N_REQ-1:0]   req_ack,
  input  logic               stop_req,
  output logic [5:0]         snd_sel,
  output logic               snd_rst,
  output logic               busy,
  output logic [2:0]         cur_req
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [5:0]       CUE_IDLE = 6'h3F;
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] RST_LD   = CNT_W'(RST_CYC - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_GAP, ST_RST} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [5:0]       sel_nx;
  logic             rst_nx;
  logic [N_REQ-1:0] ack_nx;
  logic [2:0]       cur_nx;
  logic             any_req;
  logic [IW-1:0]    win_idx;
  logic [5:0]       win_cue;
  logic [5:0]       cue_arr [N_REQ];

`ifdef SND_ARB_RR_EN
  logic [IW-1:0]    rr_ptr, rr_nx;
`endif

  always_comb begin
    for (int i = 0; i < N_REQ; i++) cue_arr[i] = req_cue[6*i +: 6];
  end

  always_comb begin
    any_req = 1'b0;
    win_idx = '0;
`ifdef SND_ARB_RR_EN
    // search upward from the pointer; first hit wins
    for (int k = 0; k < N_REQ; k++) begin
      if (!any_req && req_valid[IW'((int'(rr_ptr) + k) % N_REQ)]) begin
        any_req = 1'b1;
        win_idx = IW'((int'(rr_ptr) + k) % N_REQ);
      end
    end
`else
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        any_req = 1'b1;
        win_idx = IW'(i);
      end
    end
`endif
    win_cue = cue_arr[win_idx];
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    sel_nx   = snd_sel;
    rst_nx   = snd_rst;
    ack_nx   = '0;
    cur_nx   = cur_req;
`ifdef SND_ARB_RR_EN
    rr_nx    = rr_ptr;
`endif
    unique case (state)
      ST_IDLE: begin
        if (stop_req) begin
          state_nx = ST_RST;
          cnt_nx   = RST_LD;
          rst_nx   = 1'b1;
        end else if (any_req) begin
          ack_nx = N_REQ'(1) << win_idx;
          cur_nx = 3'(win_idx);
`ifdef SND_ARB_RR_EN
          rr_nx  = IW'((int'(win_idx) + 1) % N_REQ);
`endif
          // an all-ones cue is a null cue: grant consumed, board untouched
          if (win_cue != CUE_IDLE) begin
            sel_nx   = win_cue;
            cnt_nx   = HOLD_LD;
            state_nx = ST_HOLD;
          end
        end
      end
      ST_HOLD, ST_GAP: begin
        if (stop_req) begin
          state_nx = ST_RST;
          cnt_nx   = RST_LD;
          rst_nx   = 1'b1;
          sel_nx   = CUE_IDLE;
        end else if (cnt == '0) begin
          sel_nx = CUE_IDLE;
          if (state == ST_HOLD) begin
            cnt_nx   = GAP_LD;
            state_nx = ST_GAP;
          end else begin
            state_nx = ST_IDLE;
          end
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      ST_RST: begin
        if (cnt == '0) begin
          rst_nx   = 1'b0;
          cnt_nx   = GAP_LD;
          state_nx = ST_GAP;
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      snd_sel <= CUE_IDLE;
      snd_rst <= 1'b0;
      req_ack <= '0;
      cur_req <= '0;
`ifdef SND_ARB_RR_EN
      rr_ptr  <= '0;
`endif
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      snd_sel <= sel_nx;
      snd_rst <= rst_nx;
      req_ack <= ack_nx;
      cur_req <= cur_nx;
`ifdef SND_ARB_RR_EN
      rr_ptr  <= rr_nx;
`endif
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_sound_cue_arbiter.sv
// Bench for sound_cue_arbiter: schedule-based reference model checked every cycle, directed scenarios, then random traffic.
module tb_sound_cue_arbiter;

  localparam int N = 4;
  localparam int H = 4;
  localparam int G = 2;
  localparam int R = 3;

  logic           PCLK;
  logic           PRESET;
  logic [N-1:0]   req_valid;
  logic [6*N-1:0] req_cue;
  logic [N-1:0]   req_ack;
  logic           stop_req;
  logic [5:0]     snd_sel;
  logic           snd_rst;
  logic           busy;
  logic [2:0]     cur_req;

  int errors = 0;
  int checks = 0;
  bit keep_valid = 0;

  sound_cue_arbiter #(.N_REQ(N), .CNT_W(16), .HOLD_CYC(H), .GAP_CYC(G), .RST_CYC(R)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .req_valid(req_valid), .req_cue(req_cue),
    .req_ack(req_ack), .stop_req(stop_req), .snd_sel(snd_sel), .snd_rst(snd_rst),
    .busy(busy), .cur_req(cur_req)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each grant/stop books absolute cycle windows for the cue, the reset and busy.
  int       n = 0;
  bit       m_ok = 0;
  int       sel_until, rst_until, busy_until;
  int       m_ptr;
  logic [5:0]   m_cue, m_sel;
  logic         m_rst, m_busy;
  logic [N-1:0] m_ack;
  logic [2:0]   m_cur;

  always @(posedge PCLK) begin
    int w;
    logic [5:0] c;
    n++;
    m_ack = '0;
    if (PRESET) begin
      m_ok = 1; sel_until = -1; rst_until = -1; busy_until = -1;
      m_ptr = 0; m_cur = 0; m_cue = 6'h3F;
    end else if (m_ok) begin
      if (n - 1 > busy_until) begin
        if (stop_req) begin
          rst_until = n + R - 1; busy_until = n + R + G - 1;
        end else if (req_valid != '0) begin
          w = -1;
`ifdef SND_ARB_RR_EN
          for (int k = 0; k < N; k++)
            if (w < 0 && req_valid[(m_ptr + k) % N]) w = (m_ptr + k) % N;
`else
          for (int k = 0; k < N; k++)
            if (w < 0 && req_valid[k]) w = k;
`endif
          m_ack[w] = 1'b1;
          m_cur = 3'(w);
          m_ptr = (w + 1) % N;
          c = req_cue[6*w +: 6];
          if (c != 6'h3F) begin
            m_cue = c; sel_until = n + H - 1; busy_until = n + H + G - 1;
          end
        end
      end else if (stop_req && n - 1 > rst_until) begin
        sel_until = n - 1; rst_until = n + R - 1; busy_until = n + R + G - 1;
      end
    end
    m_sel  = (n <= sel_until) ? m_cue : 6'h3F;
    m_rst  = (n <= rst_until);
    m_busy = (n <= busy_until);
  end

  always @(negedge PCLK) begin
    if (m_ok) begin
      chk("model_snd_sel", snd_sel, m_sel);
      chk("model_snd_rst", snd_rst, m_rst);
      chk("model_busy", busy, m_busy);
      chk("model_req_ack", req_ack, m_ack);
      chk("model_cur_req", cur_req, m_cur);
    end
  end

  task automatic step();
    @(posedge PCLK);
    #1;
    if (!keep_valid) req_valid = req_valid & ~req_ack;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 40) begin step(); k++; end
    chk("wait_idle_timeout", busy, 0);
  endtask

  initial begin
    int n_sel, n_busy, n_ack, n_rst, n_gap, cnt, ng;
    int g_idx [8];
    int g_cyc [8];
    PRESET = 1; req_valid = '0; req_cue = '1; stop_req = 0;

    // 1: reset
    step(); step();
    PRESET = 0;
    chk("rst_snd_sel", snd_sel, 6'h3F);
    chk("rst_snd_rst", snd_rst, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req_ack", req_ack, 4'b0000);
    chk("rst_cur_req", cur_req, 0);

    // 2: single cue on requester 1
    req_cue[11:6] = 6'h3E; req_valid = 4'b0010;
    step();
    chk("t2_ack", req_ack, 4'b0010);
    chk("t2_cur_req", cur_req, 1);
    n_sel = (snd_sel == 6'h3E); n_busy = busy; n_ack = (req_ack != 0);
    for (int i = 0; i < 20 && busy; i++) begin
      step();
      n_sel += (snd_sel == 6'h3E); n_busy += busy; n_ack += (req_ack != 0);
    end
    chk("t2_sel_cycles", n_sel, 4);
    chk("t2_busy_cycles", n_busy, 6);
    chk("t2_ack_pulses", n_ack, 1);

    // 3: two requesters held
    keep_valid = 1;
    req_cue[5:0] = 6'h3D; req_cue[17:12] = 6'h3B; req_valid = 4'b0101;
    ng = 0;
    for (int i = 0; i < 25; i++) begin
      step();
      if (req_ack != 0 && ng < 8) begin
        g_idx[ng] = (req_ack == 4'b0001) ? 0 : (req_ack == 4'b0100) ? 2 : 9;
        g_cyc[ng] = i; ng++;
      end
    end
    chk("t3_grant_count", ng, 4);
`ifdef SND_ARB_RR_EN
    chk("t3_order0", g_idx[0], 0); chk("t3_order1", g_idx[1], 2);
    chk("t3_order2", g_idx[2], 0); chk("t3_order3", g_idx[3], 2);
`else
    chk("t3_order0", g_idx[0], 0); chk("t3_order1", g_idx[1], 0);
    chk("t3_order2", g_idx[2], 0);
`endif
    chk("t3_spacing01", g_cyc[1] - g_cyc[0], 7);
    chk("t3_spacing12", g_cyc[2] - g_cyc[1], 7);
    keep_valid = 0; req_valid = '0;
    wait_idle();

    // 4: stop on second HOLD cycle with a pending request
    req_cue[5:0] = 6'h3D; req_valid = 4'b0001;
    step();
    chk("t4_hold_sel", snd_sel, 6'h3D);
    req_cue[11:6] = 6'h3E; req_valid[1] = 1'b1;
    step();
    stop_req = 1;
    step();
    stop_req = 0;
    chk("t4_stop_sel", snd_sel, 6'h3F);
    chk("t4_stop_rst", snd_rst, 1);
    n_rst = 1; n_gap = 0; n_ack = (req_ack != 0);
    for (int i = 0; i < 10 && snd_rst; i++) begin
      step(); n_rst += snd_rst; n_ack += (req_ack != 0);
    end
    n_rst -= snd_rst ? 0 : 0;
    n_gap = busy;
    for (int i = 0; i < 10 && busy; i++) begin
      step(); n_gap += busy; n_ack += (req_ack != 0);
    end
    chk("t4_rst_cycles", n_rst, 3);
    chk("t4_gap_cycles", n_gap, 2);
    chk("t4_no_early_ack", n_ack, 0);
    step();
    chk("t4_pending_ack", req_ack, 4'b0010);
    chk("t4_pending_sel", snd_sel, 6'h3E);
    wait_idle();

    // 5: stop and request in the same IDLE cycle
    stop_req = 1; req_cue[5:0] = 6'h3D; req_valid = 4'b0001;
    step();
    stop_req = 0;
    chk("t5_no_ack", req_ack, 0);
    chk("t5_rst", snd_rst, 1);
    cnt = 0;
    while (req_ack == 0 && cnt < 20) begin step(); cnt++; end
    chk("t5_ack_delay", cnt, 6);
    chk("t5_ack", req_ack, 4'b0001);
    wait_idle();

    // 6: null cue
    req_cue[5:0] = 6'h3F; req_valid = 4'b0001;
    step();
    chk("t6_ack", req_ack, 4'b0001);
    chk("t6_sel", snd_sel, 6'h3F);
    chk("t6_busy", busy, 0);
    step();
    chk("t6_ack_once", req_ack, 0);
    chk("t6_busy_after", busy, 0);

    // 7: reset during HOLD
    req_cue[11:6] = 6'h3E; req_valid = 4'b0010;
    step();
    chk("t7_hold_sel", snd_sel, 6'h3E);
    step();
    PRESET = 1;
    step();
    PRESET = 0;
    chk("t7_sel", snd_sel, 6'h3F);
    chk("t7_busy", busy, 0);
    chk("t7_ack", req_ack, 0);
    chk("t7_cur_req", cur_req, 0);

    // random traffic
    req_valid = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 7) == 0) begin
          req_cue[6*i +: 6] = ($urandom_range(0, 7) == 0) ? 6'h3F : 6'($urandom);
          req_valid[i] = 1'b1;
        end else if (req_valid[i] && $urandom_range(0, 99) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      stop_req = ($urandom_range(0, 39) == 0);
      PRESET = ($urandom_range(0, 599) == 0);
      step();
    end
    PRESET = 0; stop_req = 0; req_valid = '0;
    step(); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
